// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: default parameters and width derivation shared by the virtual-channel FIFO.
package vc_fifo_pkg;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH_W = 2;
    localparam int DEF_VC_NUM       = 2;
    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int depth_w);
        return depth_w + 1;
    endfunction
endpackage

// File: rtl/vc_fifo_ch.sv
// vc_fifo_ch: one virtual channel -- storage, wrap-bit pointers, occupancy, status and sticky error flags.
module vc_fifo_ch
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH_W = DEF_FIFO_DEPTH_W,
    parameter int AFULL_TH     = (2 ** FIFO_DEPTH_W) - 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_i,
    input  logic                    rd_i,
    input  logic                    err_clr_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    rd_acc_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    afull_o,
    output logic [FIFO_DEPTH_W:0]   count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_W;
    logic [FIFO_DEPTH_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  wr_acc, ovf_q, ovf_d, udf_q, udf_d;
    assign empty_o  = wr_ptr_q == rd_ptr_q;
    assign full_o   = (wr_ptr_q[FIFO_DEPTH_W] != rd_ptr_q[FIFO_DEPTH_W]) &&
                      (wr_ptr_q[FIFO_DEPTH_W-1:0] == rd_ptr_q[FIFO_DEPTH_W-1:0]);
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign afull_o  = int'(count_o) >= AFULL_TH;
    assign data_o   = mem_q[rd_ptr_q[FIFO_DEPTH_W-1:0]];
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
    // Acceptance: a full channel still takes a write when the same cycle frees a slot; no write-to-read bypass.
    always_comb begin
        rd_acc_o = rd_i & ~empty_o;
        wr_acc   = wr_i & (~full_o | rd_acc_o);
        wr_ptr_d = wr_ptr_q + {{FIFO_DEPTH_W{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{FIFO_DEPTH_W{1'b0}}, rd_acc_o};
        ovf_d    = (wr_i & ~wr_acc) | (ovf_q & ~err_clr_i);
        udf_d    = (rd_i & ~rd_acc_o) | (udf_q & ~err_clr_i);
    end
    // Pointer and sticky flag state; reset empties the channel without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
    // Flit storage, written at the slot addressed by the low write-pointer bits.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q[FIFO_DEPTH_W-1:0]] <= data_i;
    end
endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: multi-VC flit FIFO with index decode, registered read port, credit return and error reporting.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH_W = DEF_FIFO_DEPTH_W,
    parameter int VC_NUM       = DEF_VC_NUM,
    parameter int AFULL_TH     = (2 ** FIFO_DEPTH_W) - 1,
    parameter int ID           = 0,
    localparam int VC_W        = vc_w(VC_NUM),
    localparam int CNT_W       = cnt_w(FIFO_DEPTH_W)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [VC_W-1:0]         wr_vc_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    rd_en_i,
    input  logic [VC_W-1:0]         rd_vc_i,
    input  logic                    err_clr_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    valid_o,
    output logic [VC_NUM-1:0]       full_o,
    output logic [VC_NUM-1:0]       empty_o,
    output logic [VC_NUM-1:0]       afull_o,
    output logic [VC_NUM*CNT_W-1:0] count_o,
    output logic [VC_NUM-1:0]       credit_o,
    output logic [VC_NUM-1:0]       overflow_o,
    output logic [VC_NUM-1:0]       underflow_o,
    output logic                    bad_vc_o
);
    if (VC_NUM < 2 || VC_NUM > 16) begin : g_bad_cfg
        $error("vc_fifo %0d: VC_NUM=%0d outside 2..16", ID, VC_NUM);
    end
    logic [VC_NUM-1:0] wr_oh, rd_oh, rd_acc, credit_q;
    logic [DATA_W-1:0] head [VC_NUM];
    logic [DATA_W-1:0] rd_data, data_q, data_d;
    logic              valid_q, bad_q, bad_d;
    // Shifting past the vector width yields zero, so an out-of-range index selects no channel.
    assign wr_oh = VC_NUM'(1) << wr_vc_i;
    assign rd_oh = VC_NUM'(1) << rd_vc_i;
    for (genvar v = 0; v < VC_NUM; v++) begin : g_ch
        vc_fifo_ch #(
            .DATA_W       (DATA_W),
            .FIFO_DEPTH_W (FIFO_DEPTH_W),
            .AFULL_TH     (AFULL_TH)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .wr_i        (wr_en_i & wr_oh[v]),
            .rd_i        (rd_en_i & rd_oh[v]),
            .err_clr_i   (err_clr_i),
            .data_i      (data_i),
            .data_o      (head[v]),
            .rd_acc_o    (rd_acc[v]),
            .full_o      (full_o[v]),
            .empty_o     (empty_o[v]),
            .afull_o     (afull_o[v]),
            .count_o     (count_o[v*CNT_W +: CNT_W]),
            .overflow_o  (overflow_o[v]),
            .underflow_o (underflow_o[v])
        );
    end
    // Read mux over the one-hot accepted-read vector, plus next-state of the output and bad-index flag.
    always_comb begin
        rd_data = '0;
        for (int v = 0; v < VC_NUM; v++) rd_data = rd_data | (rd_acc[v] ? head[v] : '0);
        data_d = |rd_acc ? rd_data : data_q;
        bad_d  = (wr_en_i & ~|wr_oh) | (rd_en_i & ~|rd_oh) | (bad_q & ~err_clr_i);
    end
    // Registered read port, credit pulses and sticky bad-index flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= '0;
            bad_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= |rd_acc;
            credit_q <= rd_acc;
            bad_q    <= bad_d;
        end
    end
    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign credit_o = credit_q;
    assign bad_vc_o = bad_q;
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed and random stimulus against a queue-based reference of the VC FIFO.
module tb_vc_fifo;
    localparam int DW = 8, DWD = 2, VN = 3, VW = 2, CW = 3, DEPTH = 4;
    logic           clk = 1'b0, rst_n = 1'b0;
    logic           wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [VW-1:0]  wr_vc = '0, rd_vc = '0;
    logic [DW-1:0]  din = '0;
    logic [DW-1:0]  data_o;
    logic           valid_o, bad_vc_o;
    logic [VN-1:0]  full_o, empty_o, afull_o, credit_o, overflow_o, underflow_o;
    logic [VN*CW-1:0] count_o;
    int total = 0, bad = 0;
    logic [7:0]    q [VN][$];
    logic [7:0]    e_data;
    logic          e_valid, e_bad;
    logic [VN-1:0] e_credit, e_ovf, e_udf;

    vc_fifo #(.DATA_W(DW), .FIFO_DEPTH_W(DWD), .VC_NUM(VN), .ID(7)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_vc_i(wr_vc), .data_i(din),
        .rd_en_i(rd_en), .rd_vc_i(rd_vc), .err_clr_i(err_clr), .data_o(data_o), .valid_o(valid_o),
        .full_o(full_o), .empty_o(empty_o), .afull_o(afull_o), .count_o(count_o), .credit_o(credit_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .bad_vc_o(bad_vc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VN; v++) q[v].delete();
        e_data = '0; e_valid = 1'b0; e_bad = 1'b0;
        e_credit = '0; e_ovf = '0; e_udf = '0;
    endtask

    task automatic check_all();
        chk("valid", valid_o, e_valid);
        chk("data", data_o, e_data);
        chk("credit", credit_o, e_credit);
        chk("overflow", overflow_o, e_ovf);
        chk("underflow", underflow_o, e_udf);
        chk("bad_vc", bad_vc_o, e_bad);
        for (int v = 0; v < VN; v++) begin
            chk($sformatf("count%0d", v), count_o[v*CW +: CW], q[v].size());
            chk($sformatf("full%0d", v), full_o[v], q[v].size() == DEPTH);
            chk($sformatf("empty%0d", v), empty_o[v], q[v].size() == 0);
            chk($sformatf("afull%0d", v), afull_o[v], q[v].size() >= DEPTH - 1);
        end
    endtask

    task automatic cyc(input logic we, input int wv, input logic [7:0] d,
                       input logic re, input int rv, input logic c);
        logic wl, rl, ra, wa;
        logic [VN-1:0] nov, nud;
        wr_en = we; wr_vc = wv[VW-1:0]; din = d;
        rd_en = re; rd_vc = rv[VW-1:0]; err_clr = c;
        @(posedge clk);
        wl = wv < VN; rl = rv < VN;
        ra = re && rl && q[rv].size() > 0;
        wa = we && wl && (q[wv].size() < DEPTH || (ra && rv == wv));
        nov = '0; nud = '0;
        if (we && wl && !wa) nov[wv] = 1'b1;
        if (re && rl && !ra) nud[rv] = 1'b1;
        if (ra) begin
            e_data = q[rv].pop_front();
            e_valid = 1'b1;
            e_credit = VN'(1) << rv;
        end else begin
            e_valid = 1'b0;
            e_credit = '0;
        end
        if (wa) q[wv].push_back(d);
        e_ovf = nov | (e_ovf & ~{VN{c}});
        e_udf = nud | (e_udf & ~{VN{c}});
        e_bad = (we && !wl) || (re && !rl) || (e_bad && !c);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_empty", empty_o, 3'b111);
        @(negedge clk) rst_n = 1'b1;
        // fill VC0, then overflow it
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h11 + i), 0, 0, 0);
        chk("full0_dir", full_o[0], 1'b1);
        chk("cnt0_dir", count_o[CW-1:0], 4);
        chk("empty1_dir", empty_o[1], 1'b1);
        cyc(1, 0, 8'h99, 0, 0, 0);
        chk("ovf0_dir", overflow_o[0], 1'b1);
        // drain VC0 in order, then underflow it
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 1, 0, 0);
            chk("rd_data_dir", data_o, 8'(8'h11 + i));
            chk("credit0_dir", credit_o[0], 1'b1);
        end
        cyc(0, 0, 8'h00, 1, 0, 0);
        chk("udf0_dir", underflow_o[0], 1'b1);
        chk("valid_udf_dir", valid_o, 1'b0);
        cyc(0, 0, 8'h00, 0, 0, 1);
        // simultaneous write and read on a full VC
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hA1 + i), 0, 0, 0);
        cyc(1, 0, 8'h55, 1, 0, 0);
        chk("cnt0_rw_full", count_o[CW-1:0], 4);
        chk("ovf0_rw_full", overflow_o[0], 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0, 0);
        chk("last_55", data_o, 8'h55);
        // cross-VC traffic with pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cyc(1, 1, 8'($urandom), 1, 0, 0);
            else cyc(1, 0, 8'($urandom), 1, 1, 0);
        end
        cyc(0, 0, 8'h00, 0, 0, 1);
        // illegal indices and clear priority
        cyc(1, 3, 8'hEE, 0, 0, 0);
        chk("bad_wr", bad_vc_o, 1'b1);
        cyc(0, 0, 8'h00, 1, 3, 1);
        chk("bad_clr_race", bad_vc_o, 1'b1);
        cyc(0, 0, 8'h00, 0, 0, 1);
        chk("bad_cleared", bad_vc_o, 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
        // asynchronous reset in the middle of a cycle with VC0 holding two flits
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h31 + i), 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0);
        chk("pre_rst_valid", valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("mid_rst_empty", empty_o, 3'b111);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_valid", valid_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cyc(1, 2, 8'h77, 0, 0, 0);
        chk("first_edge_wr", count_o[2*CW +: CW], 1);
        cyc(0, 0, 8'h00, 1, 2, 0);
        chk("first_edge_rd", data_o, 8'h77);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
